// File: rtl/pipeline_addsub_pkg.sv
// Shared definitions for the segmented pipelined adder/subtractor.
//   handshake_t : {valid, ready} pair, common to the pipelined arithmetic blocks
//   stages()    : number of pipeline stages for a WIDTH/SEG pair
//   seg_fits()  : legality test for a WIDTH/SEG pair (SEG divides WIDTH)
//   max1()      : clamps a computed width to at least one bit
package pipeline_addsub_pkg;

    typedef struct packed {
        logic valid;
        logic ready;
    } handshake_t;

    function automatic int stages(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit seg_fits(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

    // Last-stage operand registers have no bits left to hold; clamping
    // to a one-bit minimum keeps every port width legal.
    function automatic int max1(input int x);
        return (x < 1) ? 1 : x;
    endfunction

endpackage

// File: rtl/pipeline_addsub_seg.sv
// One SEG-bit slice of the pipelined adder: adds the lowest remaining
// segment of a/bx plus the incoming carry and registers the result.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   up_valid    : upstream stage (or input) holds a transaction
//   load        : this stage's ready; the stage may take new contents
//   a_in, b_in  : not-yet-consumed high segments of a and bx
//   c_in        : carry out of the previous segment
//   lo_in       : finished low sum segments from earlier stages
//   v_out       : this stage's valid bit
//   a_out, b_out: remaining segments for later stages
//   c_out       : carry out of this segment
//   cmsb_out    : carry into the top bit of this segment (used in last stage)
//   lo_out      : finished sum bits including this segment
module pipeline_addsub_seg
    import pipeline_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int IDX   = 0,
    localparam int IN_W     = WIDTH - IDX * SEG,
    localparam int OUT_W    = max1(IN_W - SEG),
    localparam int LO_IN_W  = max1(IDX * SEG),
    localparam int LO_OUT_W = (IDX + 1) * SEG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                up_valid,
    input  logic                load,
    input  logic [IN_W-1:0]     a_in,
    input  logic [IN_W-1:0]     b_in,
    input  logic                c_in,
    input  logic [LO_IN_W-1:0]  lo_in,
    output logic                v_out,
    output logic [OUT_W-1:0]    a_out,
    output logic [OUT_W-1:0]    b_out,
    output logic                c_out,
    output logic                cmsb_out,
    output logic [LO_OUT_W-1:0] lo_out
);

    logic [SEG:0]      seg_sum;
    logic              cmsb_next;
    logic [LO_OUT_W-1:0] lo_next;
    logic [OUT_W-1:0]  a_next;
    logic [OUT_W-1:0]  b_next;

    logic                v_reg;
    logic [OUT_W-1:0]    a_reg;
    logic [OUT_W-1:0]    b_reg;
    logic                c_reg;
    logic                cmsb_reg;
    logic [LO_OUT_W-1:0] lo_reg;

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    // Sum bit = a ^ b ^ carry_in, so the carry into the segment's top bit
    // falls out of the existing adder without a second narrower one.
    assign cmsb_next = seg_sum[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1];

    if (IDX == 0) begin : g_lo_first
        assign lo_next = seg_sum[SEG-1:0];
    end else begin : g_lo_shift
        assign lo_next = {seg_sum[SEG-1:0], lo_in};
    end

    if (IN_W > SEG) begin : g_hi_carry
        assign a_next = a_in[IN_W-1:SEG];
        assign b_next = b_in[IN_W-1:SEG];
    end else begin : g_hi_none
        assign a_next = '0;
        assign b_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= 1'b0;
            cmsb_reg <= 1'b0;
            lo_reg   <= '0;
        end else begin
            if (load) begin
                v_reg <= up_valid;
            end
            // Data only moves with a real transaction so a held result
            // (or a drained stage) keeps its last contents.
            if (load && up_valid) begin
                a_reg    <= a_next;
                b_reg    <= b_next;
                c_reg    <= seg_sum[SEG];
                cmsb_reg <= cmsb_next;
                lo_reg   <= lo_next;
            end
        end
    end

    assign v_out    = v_reg;
    assign a_out    = a_reg;
    assign b_out    = b_reg;
    assign c_out    = c_reg;
    assign cmsb_out = cmsb_reg;
    assign lo_out   = lo_reg;

endmodule

// File: rtl/pipeline_addsub.sv
// Segmented pipelined adder/subtractor, WIDTH/SEG stages, with valid/ready
// flow control and signed-overflow reporting.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready combinational from out_ready)
//   a, b, cin, sub       : operands; sub=1 computes a - b - cin
//   out_valid / out_ready: output handshake
//   sum, cout, ovf       : result mod 2^WIDTH, raw carry out, signed overflow
module pipeline_addsub
    import pipeline_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, SEG);

    if (!seg_fits(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipeline_addsub: WIDTH must be a non-zero multiple of SEG");
    end

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : gen_stage
        localparam int IN_W     = WIDTH - gi * SEG;
        localparam int OUT_W    = max1(IN_W - SEG);
        localparam int LO_IN_W  = max1(gi * SEG);
        localparam int LO_OUT_W = (gi + 1) * SEG;

        handshake_t          hs;
        logic                up_valid;
        logic                v;
        logic [IN_W-1:0]     a_in;
        logic [IN_W-1:0]     b_in;
        logic                c_in;
        logic [LO_IN_W-1:0]  lo_in;
        logic [OUT_W-1:0]    a_o;
        logic [OUT_W-1:0]    b_o;
        logic                c_o;
        logic                cm_o;
        logic [LO_OUT_W-1:0] lo_o;

        if (gi == 0) begin : g_head
            // Subtraction is a + ~b + ~borrow, folded in before stage 1.
            assign up_valid = in_valid;
            assign a_in     = a;
            assign b_in     = sub ? ~b : b;
            assign c_in     = sub ? ~cin : cin;
            assign lo_in    = '0;
        end else begin : g_link
            assign up_valid = gen_stage[gi-1].hs.valid;
            assign a_in     = gen_stage[gi-1].a_o;
            assign b_in     = gen_stage[gi-1].b_o;
            assign c_in     = gen_stage[gi-1].c_o;
            assign lo_in    = gen_stage[gi-1].lo_o;
        end

        // An empty stage can always fill, which lets bubbles collapse
        // behind a stalled consumer.
        if (gi == STAGES - 1) begin : g_tail_ready
            assign hs.ready = !v || out_ready;
        end else begin : g_mid_ready
            assign hs.ready = !v || gen_stage[gi+1].hs.ready;
        end
        assign hs.valid = v;

        pipeline_addsub_seg #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (gi)
        ) u_seg (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (up_valid),
            .load     (hs.ready),
            .a_in     (a_in),
            .b_in     (b_in),
            .c_in     (c_in),
            .lo_in    (lo_in),
            .v_out    (v),
            .a_out    (a_o),
            .b_out    (b_o),
            .c_out    (c_o),
            .cmsb_out (cm_o),
            .lo_out   (lo_o)
        );
    end

    assign in_ready  = gen_stage[0].hs.ready;
    assign out_valid = gen_stage[STAGES-1].hs.valid;
    assign sum       = gen_stage[STAGES-1].lo_o;
    assign cout      = gen_stage[STAGES-1].c_o;
    assign ovf       = gen_stage[STAGES-1].cm_o ^ gen_stage[STAGES-1].c_o;

endmodule

// File: tb/tb_pipeline_addsub.sv
module tb_pipeline_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 32/8 default instance
    logic        iv0, ir0, cin0, sub0, ov0, or0, cout0, ovf0;
    logic [31:0] a0, b0, sum0;
    // 16/4 instance
    logic        iv1, ir1, cin1, sub1, ov1, or1, cout1, ovf1;
    logic [15:0] a1, b1, sum1;
    // 24/24 single-stage instance
    logic        iv2, ir2, cin2, sub2, ov2, or2, cout2, ovf2;
    logic [23:0] a2, b2, sum2;

    pipeline_addsub #(.WIDTH(32), .SEG(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(sum0),
        .cout(cout0), .ovf(ovf0));

    pipeline_addsub #(.WIDTH(16), .SEG(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(sum1),
        .cout(cout1), .ovf(ovf1));

    pipeline_addsub #(.WIDTH(24), .SEG(24)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .cin(cin2), .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(sum2),
        .cout(cout2), .ovf(ovf2));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    item_t q2[$];

    // Reference: {ovf, cout, sum}. Overflow from operand/result signs.
    function automatic logic [33:0] ref_calc(input int w, input logic [31:0] a_i,
                                             input logic [31:0] b_i, input logic ci,
                                             input logic su);
        logic [32:0] mask, bx, full;
        logic c0, co, ov;
        mask = (33'd1 << w) - 33'd1;
        bx   = su ? ((~{1'b0, b_i}) & mask) : {1'b0, b_i};
        c0   = su ? ~ci : ci;
        full = {1'b0, a_i} + bx + {32'd0, c0};
        co   = full[w];
        ov   = (a_i[w-1] == bx[w-1]) && (full[w-1] != a_i[w-1]);
        return {ov, co, full[31:0] & mask[31:0]};
    endfunction

    task automatic drive0(input logic v, input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic ci, input logic su, input logic ordy);
        @(negedge clk);
        iv0 = v; a0 = a_i; b0 = b_i; cin0 = ci; sub0 = su; or0 = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv0 = 0; a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; or0 = 1;
        iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
        iv2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; or2 = 1;
        #12;
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
        total++; if (sum0 !== 32'd0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum0); end
        total++; if ({cout0, ovf0} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf: got %b want 00", {cout0, ovf0}); end
        total++; if ({ov1, ov2} !== 2'b00) begin bad++; $display("FAIL reset_sweep_valid: got %b want 00", {ov1, ov2}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", ir0); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %b want 0", ov0); end
    endtask

    task automatic test_add_sub();
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic        vs [3];
        logic [33:0] ve [3];
        item_t e;
        int idx, n;
        va = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
        vb = '{32'h0000_0001, 32'h0000_0001, 32'd7};
        vs = '{1'b0, 1'b1, 1'b1};
        ve = '{{1'b0, 1'b1, 32'h0000_0000}, {1'b1, 1'b1, 32'h7FFF_FFFF}, {1'b0, 1'b0, 32'hFFFF_FFFE}};
        n = 0;
        for (int t = 0; t < 20; t++) begin
            idx = (n < 3) ? n : 0;
            drive0(n < 3, va[idx], vb[idx], 1'b0, vs[idx], 1'b1);
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    total++; bad++; $display("FAIL addsub_spurious: got sum %h want nothing", sum0);
                end else begin
                    e = q0.pop_front();
                    total++;
                    if ({ovf0, cout0, sum0} !== {e.ovf, e.cout, e.sum}) begin
                        bad++; $display("FAIL addsub_result: got %b %b %h want %b %b %h", ovf0, cout0, sum0, e.ovf, e.cout, e.sum);
                    end
                    total++;
                    if (cyc - e.cyc != 4) begin
                        bad++; $display("FAIL addsub_latency: got %0d want 4", cyc - e.cyc);
                    end
                end
            end
            if (iv0 && ir0) begin
                q0.push_back('{sum: ve[n][31:0], cout: ve[n][32], ovf: ve[n][33], cyc: cyc});
                n++;
            end
            if (n == 3 && q0.size() == 0) break;
        end
        total++;
        if (n != 3 || q0.size() != 0) begin
            bad++; $display("FAIL addsub_timeout: got sent=%0d pending=%0d want 3 and 0", n, q0.size());
        end
    endtask

    task automatic test_back_to_back();
        item_t e;
        int n, popped;
        logic ordy, prev_stall, saw_full;
        logic [34:0] held;
        n = 0; popped = 0; prev_stall = 0; saw_full = 0; held = '0;
        for (int t = 0; t < 40; t++) begin
            ordy = !(t >= 5 && t <= 9);
            drive0(n < 8, 32'(n), 32'(n), 1'b1, 1'b0, ordy);
            total++;
            if (ir0 !== ((q0.size() < 4) || ordy)) begin
                bad++; $display("FAIL b2b_in_ready t=%0d: got %b want %b", t, ir0, (q0.size() < 4) || ordy);
            end
            if (ir0 === 1'b0) saw_full = 1;
            if (prev_stall) begin
                total++;
                if ({ov0, ovf0, cout0, sum0} !== held) begin
                    bad++; $display("FAIL b2b_stable t=%0d: got %h want %h", t, {ov0, ovf0, cout0, sum0}, held);
                end
            end
            prev_stall = ov0 && !or0;
            held = {ov0, ovf0, cout0, sum0};
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    total++; bad++; $display("FAIL b2b_spurious: got sum %h want nothing", sum0);
                end else begin
                    e = q0.pop_front();
                    popped++;
                    total++;
                    if ({ovf0, cout0, sum0} !== {e.ovf, e.cout, e.sum}) begin
                        bad++; $display("FAIL b2b_result: got %b %b %h want %b %b %h", ovf0, cout0, sum0, e.ovf, e.cout, e.sum);
                    end
                end
            end
            if (iv0 && ir0) begin
                q0.push_back('{sum: 32'(2 * n + 1), cout: 1'b0, ovf: 1'b0, cyc: cyc});
                n++;
            end
            if (n == 8 && q0.size() == 0) break;
        end
        total++;
        if (popped != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", popped); end
        total++;
        if (!saw_full) begin bad++; $display("FAIL b2b_backpressure: got in_ready never 0 want 0 when full"); end
    endtask

    task automatic test_bubble();
        item_t e;
        logic v, ordy;
        logic [33:0] r;
        for (int t = 0; t < 40; t++) begin
            v    = (t == 0) || (t >= 6 && t < 12);
            ordy = (t >= 12);
            drive0(v, 32'h11 + 32'(t), 32'h22, 1'b0, 1'b0, ordy);
            if (t >= 1 && t <= 5) begin
                total++;
                if (ov0 !== (t >= 4)) begin bad++; $display("FAIL bubble_arrive t=%0d: got %b want %b", t, ov0, t >= 4); end
            end
            if (v) begin
                total++;
                if (ir0 !== ((q0.size() < 4) || ordy)) begin
                    bad++; $display("FAIL bubble_in_ready t=%0d: got %b want %b", t, ir0, (q0.size() < 4) || ordy);
                end
            end
            if (ov0 && or0) begin
                if (q0.size() == 0) begin
                    total++; bad++; $display("FAIL bubble_spurious: got sum %h want nothing", sum0);
                end else begin
                    e = q0.pop_front();
                    total++;
                    if ({ovf0, cout0, sum0} !== {e.ovf, e.cout, e.sum}) begin
                        bad++; $display("FAIL bubble_result: got %b %b %h want %b %b %h", ovf0, cout0, sum0, e.ovf, e.cout, e.sum);
                    end
                end
            end
            if (iv0 && ir0) begin
                r = ref_calc(32, a0, b0, cin0, sub0);
                q0.push_back('{sum: r[31:0], cout: r[32], ovf: r[33], cyc: cyc});
            end
            if (t >= 12 && q0.size() == 0) break;
        end
        total++;
        if (q0.size() != 0) begin bad++; $display("FAIL bubble_drain: got pending=%0d want 0", q0.size()); end
    endtask

    task automatic test_reset_mid();
        item_t e;
        int seen;
        for (int t = 0; t < 4; t++) begin
            drive0(t < 3, 32'h100 + 32'(t), 32'd1, 1'b0, 1'b0, 1'b0);
            if (iv0 && ir0) q0.push_back('{sum: 32'h101 + 32'(t), cout: 1'b0, ovf: 1'b0, cyc: cyc});
        end
        @(negedge clk);
        #1;
        total++;
        if ({ov0, sum0} !== {1'b1, 32'h101}) begin bad++; $display("FAIL midrst_before: got %b %h want 1 00000101", ov0, sum0); end
        rst_n = 1'b0;
        #1;
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", ov0); end
        total++; if (sum0 !== 32'd0) begin bad++; $display("FAIL midrst_sum: got %h want 0", sum0); end
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", ir0); end
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 9; t++) begin
            drive0(t == 0, 32'h55, 32'h66, 1'b0, 1'b0, 1'b1);
            if (t == 0) begin
                total++;
                if (!(iv0 && ir0)) begin bad++; $display("FAIL midrst_accept: got in_ready %b want 1", ir0); end
                else q0.push_back('{sum: 32'hBB, cout: 1'b0, ovf: 1'b0, cyc: cyc});
            end else begin
                total++;
                if (ov0 !== (t == 4)) begin bad++; $display("FAIL midrst_timing t=%0d: got %b want %b", t, ov0, t == 4); end
                if (ov0 && q0.size() != 0) begin
                    e = q0.pop_front();
                    seen++;
                    total++;
                    if ({ovf0, cout0, sum0} !== {e.ovf, e.cout, e.sum}) begin
                        bad++; $display("FAIL midrst_result: got %b %b %h want %b %b %h", ovf0, cout0, sum0, e.ovf, e.cout, e.sum);
                    end
                end
            end
        end
        total++;
        if (seen != 1) begin bad++; $display("FAIL midrst_count: got %0d want 1", seen); end
    endtask

    task automatic test_sweep();
        localparam int N = 10000;
        item_t e;
        logic [33:0] r;
        int n1, n2, t;
        n1 = 0; n2 = 0; t = 0;
        while (!(n1 == N && n2 == N && q1.size() == 0 && q2.size() == 0) && t < 40000) begin
            @(negedge clk);
            iv1 = (n1 < N) && ($urandom_range(0, 9) < 8);
            a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom); or1 = 1'b1;
            iv2 = (n2 < N) && ($urandom_range(0, 9) < 8);
            a2 = 24'($urandom); b2 = 24'($urandom); cin2 = 1'($urandom); sub2 = 1'($urandom); or2 = 1'b1;
            #1;
            total++;
            if ({ir1, ir2} !== 2'b11) begin bad++; $display("FAIL sweep_in_ready: got %b want 11", {ir1, ir2}); end
            if (ov1) begin
                if (q1.size() == 0) begin
                    total++; bad++; $display("FAIL sweep16_spurious: got sum %h want nothing", sum1);
                end else begin
                    e = q1.pop_front();
                    total++;
                    if ({ovf1, cout1, sum1} !== {e.ovf, e.cout, e.sum[15:0]}) begin
                        bad++; $display("FAIL sweep16_result: got %b %b %h want %b %b %h", ovf1, cout1, sum1, e.ovf, e.cout, e.sum[15:0]);
                    end
                    total++;
                    if (cyc - e.cyc != 4) begin bad++; $display("FAIL sweep16_latency: got %0d want 4", cyc - e.cyc); end
                end
            end
            if (ov2) begin
                if (q2.size() == 0) begin
                    total++; bad++; $display("FAIL sweep24_spurious: got sum %h want nothing", sum2);
                end else begin
                    e = q2.pop_front();
                    total++;
                    if ({ovf2, cout2, sum2} !== {e.ovf, e.cout, e.sum[23:0]}) begin
                        bad++; $display("FAIL sweep24_result: got %b %b %h want %b %b %h", ovf2, cout2, sum2, e.ovf, e.cout, e.sum[23:0]);
                    end
                    total++;
                    if (cyc - e.cyc != 1) begin bad++; $display("FAIL sweep24_latency: got %0d want 1", cyc - e.cyc); end
                end
            end
            if (iv1 && ir1) begin
                r = ref_calc(16, {16'd0, a1}, {16'd0, b1}, cin1, sub1);
                q1.push_back('{sum: r[31:0], cout: r[32], ovf: r[33], cyc: cyc});
                n1++;
            end
            if (iv2 && ir2) begin
                r = ref_calc(24, {8'd0, a2}, {8'd0, b2}, cin2, sub2);
                q2.push_back('{sum: r[31:0], cout: r[32], ovf: r[33], cyc: cyc});
                n2++;
            end
            t++;
        end
        @(negedge clk);
        iv1 = 1'b0; iv2 = 1'b0;
        total++;
        if (n1 != N || n2 != N || q1.size() != 0 || q2.size() != 0) begin
            bad++; $display("FAIL sweep_timeout: got sent %0d/%0d pending %0d/%0d want %0d/%0d and 0/0", n1, n2, q1.size(), q2.size(), N, N);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_bubble();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
